instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage directly upstream of the instruction ROM. Owns the PC, drives ROM address
//  and chip-select (ROM samples on rising edge of CS), captures returned words into a small
//  FIFO and presents them to decode over a valid/ready handshake. Accepts PC redirects
//  (branch/jump) from execute and flushes stale words.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset
//  FIFO_DEPTH  2              instruction buffer entries (power of 2, >=2)
//  PC_STEP     4              byte increment per sequential fetch
// PORTS
//  clk             in   1   system clock, all state on rising edge
//  reset           in   1   synchronous, active-high reset
//  rom_addr        out  32  byte address to ROM, held stable while rom_cs high
//  rom_cs          out  1   ROM chip-select; ROM latches data on its rising edge
//  rom_data        in   32  ROM read data, valid the clk cycle after rom_cs rises
//  instr_valid     out  1   instr/instr_pc hold a valid entry (FIFO head)
//  instr_ready     in   1   decode accepts head this cycle
//  instr           out  32  instruction word at FIFO head
//  instr_pc        out  32  byte address of instr
//  redirect_valid  in   1   one-cycle pulse: fetch must restart at redirect_pc
//  redirect_pc     in   32  new fetch address
//  fetch_fault     out  1   (FETCH_ALIGN_CHECK_EN only) misaligned redirect trap
// BEHAVIOUR
//  - Reset: pc=RESET_PC, state=ISSUE, FIFO empty, rom_cs=0, rom_addr=RESET_PC,
//    instr_valid=0, instr=0, instr_pc=0, fetch_fault=0. Reset mid-fetch abandons it.
//  - FSM: ISSUE: if FIFO has a free slot (counting none in flight) -> rom_cs<=1,
//    rom_addr<=pc, go CAPTURE; else stay, rom_cs=0.
//    CAPTURE: rom_cs<=0; push {rom_data,rom_addr} into FIFO, pc<=pc+PC_STEP, go ISSUE.
//  - rom_cs is registered; high for exactly one clk per request, low for >=1 clk between
//    requests. Peak throughput 1 instr / 2 clk. Latency reset->first instr_valid = 3 clk.
//  - Pop: head removed when instr_valid && instr_ready. Push and pop in same cycle
//    legal at any occupancy incl. full; count unchanged.
//  - Full: ISSUE never starts a request when count==FIFO_DEPTH; no word ever dropped.
//  - Empty: instr_valid=0; instr/instr_pc hold last values (don't-care to decode).
//  - Redirect (highest priority, over push/pop): FIFO flushed (count=0, pop ignored),
//    in-flight capture discarded, pc<=redirect_pc, rom_cs<=0, state<=ISSUE.
//    First redirected word reaches instr_valid 3 clk after the pulse.
//  - Redirect coinciding with reset: reset wins.
//  - PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0, no fault.
//  - FIFO pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
// CONFIGURATION
//  FETCH_ALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]!=0 does not change pc;
//    FIFO flushed, fetch_fault=1 held, FSM parked in ISSUE with rom_cs=0 until reset
//    or next aligned redirect (clears fault).
//  Not defined: fetch_fault port absent; redirect_pc[1:0] forced to 2'b00 on load.
// TESTING
//  1 Reset, instr_ready=1, ROM[0]=32'h00000093, ROM[4]=32'h00000113 -> instr_valid at
//    clk 3 with instr=32'h00000093/instr_pc=0, then 32'h00000113/pc 4 two clk later.
//  2 instr_ready=0 for 20 clk -> exactly FIFO_DEPTH=2 rom_cs pulses, count=2, rom_cs
//    stays 0; release ready -> words from 0,4,8 in order, none lost or duplicated.
//  3 redirect_valid with redirect_pc=32'h2c during CAPTURE of pc 8 -> word from 8 never
//    presented; next instr_pc=32'h2c, instr=32'h2a771663, 3 clk after pulse.
//  4 Full FIFO with instr_ready=1 same cycle as CAPTURE push -> count stays 2, order kept.
//  5 Redirect to 32'hFFFF_FFFC -> instr_pc sequence FFFF_FFFC, 0000_0000 (wrap).
//  6 (FETCH_ALIGN_CHECK_EN) redirect_pc=32'h12 -> fetch_fault=1, no rom_cs; then
//    redirect_pc=32'h10 -> fault clears, instr=32'h00ff07b7 at pc 32'h10.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage in front of the instruction ROM.
// Owns the PC, issues one ROM request per two clocks at most, buffers returned
// words in a FIFO_DEPTH-entry FIFO and hands them to decode over valid/ready.
// Optional build macro: FETCH_ALIGN_CHECK_EN (adds fetch_fault and traps on
// misaligned redirects instead of silently aligning them).
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] PC_STEP    = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rom_addr,
  output logic        rom_cs,
  input  logic [31:0] rom_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_fault
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [0:0] ST_ISSUE   = 1'b0;
  localparam logic [0:0] ST_CAPTURE = 1'b1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [0:0]       state;
  logic [31:0]      pc;

  // FIFO storage and bookkeeping
  logic [31:0]      mem_instr [FIFO_DEPTH];
  logic [31:0]      mem_pc    [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Last word handed to decode; shown on the outputs while the FIFO is empty
  logic [31:0]      last_instr;
  logic [31:0]      last_pc;

  logic             fault_q;
  logic             redirect_aligned;
  logic             can_issue;
  logic             push_en;
  logic             pop_en;

`ifdef FETCH_ALIGN_CHECK_EN
  assign redirect_aligned = (redirect_pc[1:0] == 2'b00);

  // Sticky misaligned-redirect trap, cleared by reset or an aligned redirect
  always_ff @(posedge clk) begin
    if (reset)
      fault_q <= 1'b0;
    else if (redirect_valid)
      fault_q <= !redirect_aligned;
  end

  assign fetch_fault = fault_q;
`else
  // Without the check every redirect is accepted and its low bits are dropped
  assign redirect_aligned = 1'b1;
  assign fault_q          = 1'b0;
`endif

  // Only one request can be outstanding, and it only exists in CAPTURE, so
  // in ISSUE the occupancy alone says whether a returning word has a slot.
  // A pop in the same cycle is not counted; that costs at most one clock.
  assign can_issue = (state == ST_ISSUE) && (count < CNT_FULL) && !fault_q;

  // A redirect discards both the word being captured and any pop attempt
  assign push_en   = (state == ST_CAPTURE) && !redirect_valid;
  assign pop_en    = instr_valid && instr_ready && !redirect_valid;

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? mem_instr[rd_ptr] : last_instr;
  assign instr_pc    = instr_valid ? mem_pc[rd_ptr]    : last_pc;

  // Request FSM: ISSUE raises rom_cs for one clock, CAPTURE drops it and
  // advances the PC while the returned word is pushed
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_ISSUE;
      pc       <= RESET_PC;
      rom_cs   <= 1'b0;
      rom_addr <= RESET_PC;
    end else if (redirect_valid) begin
      state  <= ST_ISSUE;
      rom_cs <= 1'b0;
      if (redirect_aligned)
        pc <= redirect_pc & 32'hFFFF_FFFC;
    end else begin
      case (state)
        ST_ISSUE: begin
          if (can_issue) begin
            rom_cs   <= 1'b1;
            rom_addr <= pc;
            state    <= ST_CAPTURE;
          end else begin
            rom_cs <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          rom_cs <= 1'b0;
          pc     <= pc + PC_STEP;
          state  <= ST_ISSUE;
        end
        default: begin
          rom_cs <= 1'b0;
          state  <= ST_ISSUE;
        end
      endcase
    end
  end

  // FIFO data array: written on capture, no reset needed since count gates reads
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_instr[wr_ptr] <= rom_data;
      mem_pc[wr_ptr]    <= rom_addr;
    end
  end

  // FIFO pointers/occupancy; a redirect empties the buffer outright
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_instr <= '0;
      last_pc    <= '0;
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_en) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        last_instr <= mem_instr[rd_ptr];
        last_pc    <= mem_pc[rd_ptr];
      end
      case ({push_en, pop_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural ROM that latches its
// address on the rising edge of rom_cs. Inputs are driven and outputs sampled
// on the falling clock edge.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] rom_addr;
  logic        rom_cs;
  logic [31:0] rom_data = 32'hDEAD_BEEF;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  int checks = 0;
  int errors = 0;

  instr_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .rom_addr       (rom_addr),
    .rom_cs         (rom_cs),
    .rom_data       (rom_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_fault    (fetch_fault)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: rom_word = 32'h0000_0093;
      32'h0000_0004: rom_word = 32'h0000_0113;
      32'h0000_0010: rom_word = 32'h00ff_07b7;
      32'h0000_002c: rom_word = 32'h2a77_1663;
      default:       rom_word = a ^ 32'h5A5A_0000;
    endcase
  endfunction

  // ROM: data appears shortly after rom_cs rises, goes to garbage after it falls
  always @(posedge rom_cs or negedge rom_cs) begin
    #1;
    rom_data = rom_cs ? rom_word(rom_addr) : 32'hDEAD_BEEF;
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    redirect_valid = 1'b0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    instr_ready = 1'b1;
    reset = 1'b1;
    redirect_valid = 1'b0;
    tick;
    checks++;
    if ({rom_cs, rom_addr, instr_valid} !== {1'b0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_ctrl: got cs/addr/valid %h expected %h", {rom_cs, rom_addr, instr_valid}, {1'b0, 32'h0, 1'b0});
    end
    checks++;
    if ({instr, instr_pc} !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: got instr/pc %h expected 0", {instr, instr_pc});
    end
`ifdef FETCH_ALIGN_CHECK_EN
    checks++;
    if (fetch_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_fault: got %b expected 0", fetch_fault);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_first_fetch;
    tick;
    checks++;
    if ({rom_cs, rom_addr, instr_valid} !== {1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL first_issue: got cs/addr/valid %h expected %h", {rom_cs, rom_addr, instr_valid}, {1'b1, 32'h0, 1'b0});
    end
    tick;
    checks++;
    if ({rom_cs, instr_valid, instr, instr_pc} !== {1'b0, 1'b1, 32'h0000_0093, 32'h0}) begin
      errors++;
      $display("FAIL first_word: got cs/valid/instr/pc %h expected %h", {rom_cs, instr_valid, instr, instr_pc}, {1'b0, 1'b1, 32'h0000_0093, 32'h0});
    end
    tick;
    checks++;
    if ({rom_cs, rom_addr, instr_valid} !== {1'b1, 32'h4, 1'b0}) begin
      errors++;
      $display("FAIL second_issue: got cs/addr/valid %h expected %h", {rom_cs, rom_addr, instr_valid}, {1'b1, 32'h4, 1'b0});
    end
    tick;
    checks++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h0000_0113, 32'h4}) begin
      errors++;
      $display("FAIL second_word: got valid/instr/pc %h expected %h", {instr_valid, instr, instr_pc}, {1'b1, 32'h0000_0113, 32'h4});
    end
  endtask

  task automatic test_backpressure;
    int pulses = 0;
    int n = 0;
    logic [31:0] got_pc [3];
    logic [31:0] got_i  [3];
    instr_ready = 1'b0;
    apply_reset;
    repeat (20) begin
      tick;
      if (rom_cs) pulses++;
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL bp_pulses: got %0d rom_cs pulses expected 2", pulses);
    end
    checks++;
    if ({rom_cs, instr_valid, instr_pc} !== {1'b0, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL bp_hold: got cs/valid/pc %h expected %h", {rom_cs, instr_valid, instr_pc}, {1'b0, 1'b1, 32'h0});
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 20 && n < 3; i++) begin
      if (instr_valid) begin
        got_pc[n] = instr_pc;
        got_i[n]  = instr;
        n++;
      end
      tick;
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL bp_drain_count: got %0d words expected 3", n);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if ({got_pc[k], got_i[k]} !== {32'(k * 4), rom_word(32'(k * 4))}) begin
        errors++;
        $display("FAIL bp_order[%0d]: got pc/instr %h expected %h", k, {got_pc[k], got_i[k]}, {32'(k * 4), rom_word(32'(k * 4))});
      end
    end
  endtask

  task automatic test_redirect_flush;
    instr_ready = 1'b1;
    apply_reset;
    repeat (5) tick;
    checks++;
    if ({rom_cs, rom_addr} !== {1'b1, 32'h8}) begin
      errors++;
      $display("FAIL rd_setup: got cs/addr %h expected %h", {rom_cs, rom_addr}, {1'b1, 32'h8});
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h2c;
    tick;
    redirect_valid = 1'b0;
    checks++;
    if ({rom_cs, instr_valid} !== 2'b00) begin
      errors++;
      $display("FAIL rd_discard: got cs/valid %b expected 00", {rom_cs, instr_valid});
    end
    tick;
    checks++;
    if ({rom_cs, rom_addr} !== {1'b1, 32'h2c}) begin
      errors++;
      $display("FAIL rd_issue: got cs/addr %h expected %h", {rom_cs, rom_addr}, {1'b1, 32'h2c});
    end
    tick;
    checks++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h2c, 32'h2a77_1663}) begin
      errors++;
      $display("FAIL rd_word: got valid/pc/instr %h expected %h", {instr_valid, instr_pc, instr}, {1'b1, 32'h2c, 32'h2a77_1663});
    end
  endtask

  task automatic test_push_pop_full;
    int pulses = 0;
    int n = 0;
    logic [31:0] got_pc [3];
    instr_ready = 1'b0;
    apply_reset;
    tick;
    tick;
    tick;
    instr_ready = 1'b1;
    tick;  // capture of 4 coincides with pop of 0
    checks++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h4, 32'h0000_0113}) begin
      errors++;
      $display("FAIL pp_same_cycle: got valid/pc/instr %h expected %h", {instr_valid, instr_pc, instr}, {1'b1, 32'h4, 32'h0000_0113});
    end
    instr_ready = 1'b0;
    tick;
    tick;
    repeat (6) begin
      tick;
      if (rom_cs) pulses++;
    end
    checks++;
    if ({pulses, rom_cs, instr_pc} !== {32'd0, 1'b0, 32'h4}) begin
      errors++;
      $display("FAIL pp_full_stall: got pulses/cs/pc %h expected %h", {pulses, rom_cs, instr_pc}, {32'd0, 1'b0, 32'h4});
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 20 && n < 3; i++) begin
      if (instr_valid) begin
        got_pc[n] = instr_pc;
        n++;
      end
      tick;
    end
    checks++;
    if ({n, got_pc[0], got_pc[1], got_pc[2]} !== {32'd3, 32'h4, 32'h8, 32'hc}) begin
      errors++;
      $display("FAIL pp_order: got n/pcs %h expected %h", {n, got_pc[0], got_pc[1], got_pc[2]}, {32'd3, 32'h4, 32'h8, 32'hc});
    end
  endtask

  task automatic test_pc_wrap;
    instr_ready = 1'b1;
    apply_reset;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick;
    redirect_valid = 1'b0;
    tick;
    checks++;
    if ({rom_cs, rom_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      errors++;
      $display("FAIL wrap_issue: got cs/addr %h expected %h", {rom_cs, rom_addr}, {1'b1, 32'hFFFF_FFFC});
    end
    tick;
    checks++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'hFFFF_FFFC, 32'hA5A5_FFFC}) begin
      errors++;
      $display("FAIL wrap_top: got valid/pc/instr %h expected %h", {instr_valid, instr_pc, instr}, {1'b1, 32'hFFFF_FFFC, 32'hA5A5_FFFC});
    end
    tick;
    tick;
    checks++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h0, 32'h0000_0093}) begin
      errors++;
      $display("FAIL wrap_zero: got valid/pc/instr %h expected %h", {instr_valid, instr_pc, instr}, {1'b1, 32'h0, 32'h0000_0093});
    end
`ifdef FETCH_ALIGN_CHECK_EN
    checks++;
    if (fetch_fault !== 1'b0) begin
      errors++;
      $display("FAIL wrap_fault: got %b expected 0", fetch_fault);
    end
`endif
  endtask

  task automatic test_misaligned;
    instr_ready = 1'b0;
    apply_reset;
    tick;
    tick;
    redirect_valid = 1'b1;
    redirect_pc = 32'h12;
    tick;
    redirect_valid = 1'b0;
    checks++;
    if ({rom_cs, instr_valid} !== 2'b00) begin
      errors++;
      $display("FAIL mis_flush: got cs/valid %b expected 00", {rom_cs, instr_valid});
    end
`ifdef FETCH_ALIGN_CHECK_EN
    begin
      int pulses = 0;
      instr_ready = 1'b1;
      repeat (6) begin
        tick;
        if (rom_cs) pulses++;
      end
      checks++;
      if ({fetch_fault, pulses, instr_valid} !== {1'b1, 32'd0, 1'b0}) begin
        errors++;
        $display("FAIL mis_parked: got fault/pulses/valid %h expected %h", {fetch_fault, pulses, instr_valid}, {1'b1, 32'd0, 1'b0});
      end
      redirect_valid = 1'b1;
      redirect_pc = 32'h10;
      tick;
      redirect_valid = 1'b0;
      checks++;
      if (fetch_fault !== 1'b0) begin
        errors++;
        $display("FAIL mis_clear: got fault %b expected 0", fetch_fault);
      end
    end
`else
    instr_ready = 1'b1;
`endif
    tick;
    checks++;
    if ({rom_cs, rom_addr} !== {1'b1, 32'h10}) begin
      errors++;
      $display("FAIL mis_issue: got cs/addr %h expected %h", {rom_cs, rom_addr}, {1'b1, 32'h10});
    end
    tick;
    checks++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h10, 32'h00ff_07b7}) begin
      errors++;
      $display("FAIL mis_word: got valid/pc/instr %h expected %h", {instr_valid, instr_pc, instr}, {1'b1, 32'h10, 32'h00ff_07b7});
    end
  endtask

  task automatic test_reset_mid_fetch;
    instr_ready = 1'b1;
    apply_reset;
    tick;
    reset = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h2c;
    tick;
    checks++;
    if ({rom_cs, instr_valid, rom_addr} !== {1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL rst_mid: got cs/valid/addr %h expected %h", {rom_cs, instr_valid, rom_addr}, {1'b0, 1'b0, 32'h0});
    end
    reset = 1'b0;
    redirect_valid = 1'b0;
    tick;
    tick;
    checks++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h0, 32'h0000_0093}) begin
      errors++;
      $display("FAIL rst_restart: got valid/pc/instr %h expected %h", {instr_valid, instr_pc, instr}, {1'b1, 32'h0, 32'h0000_0093});
    end
  endtask

  initial begin
    test_reset;
    test_first_fetch;
    test_backpressure;
    test_redirect_flush;
    test_push_pop_full;
    test_pc_wrap;
    test_misaligned;
    test_reset_mid_fetch;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
